i2s_tx: RTL

I2S_TX -- requirements
Module: i2s_tx

---
 rtl/radio24bb_aud_pkg.sv | 17 +
 rtl/i2s_edge_det.sv | 24 ++
 rtl/i2s_tx.sv | 130 +++++++++++++
 3 files changed

// File: rtl/radio24bb_aud_pkg.sv
// Shared audio types: default slot width, channel encoding of wclk and the {left, right} sample pair.
// Pure declarations, no logic and no flow control.
package radio24bb_aud_pkg;

  localparam int DATA_W_DEFAULT = 16;

  typedef enum logic {
    CH_LEFT  = 1'b0,
    CH_RIGHT = 1'b1
  } ch_e;

  typedef struct packed {
    logic [DATA_W_DEFAULT-1:0] left;
    logic [DATA_W_DEFAULT-1:0] right;
  } pair_t;

endpackage

// File: rtl/i2s_edge_det.sv
// Registers a clk-synchronous level and flags its edges; pulses are valid in the cycle the new level arrives.
// One register of latency for the delayed copy; no backpressure.
module i2s_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic sig_i,
  output logic rise_o,
  output logic fall_o
);

  logic sig_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig_q <= 1'b0;
    end else begin
      sig_q <= sig_i;
    end
  end

  assign rise_o = sig_i & ~sig_q;
  assign fall_o = ~sig_i & sig_q;

endmodule

// File: rtl/i2s_tx.sv
// I2S transmitter: one-pair holding register feeding a slot shifter that advances on bclk falling edges.
// sdata/pulses are registered in the fe cycle; s_tready drops while a pair is held or en is low.
module i2s_tx
  import radio24bb_aud_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                bclk,
  input  logic                wclk,
  input  logic                en,
  input  logic [2*DATA_W-1:0] s_tdata,
  input  logic                s_tvalid,
  output logic                s_tready,
  output logic                sdata,
  output logic                frame_start,
  output logic                underrun,
  output logic [15:0]         underrun_cnt
);

  logic bclk_fe;
  logic bclk_rise_unused;

  i2s_edge_det u_bclk_det (
    .clk    (clk),
    .rst_n  (reset),
    .sig_i  (bclk),
    .rise_o (bclk_rise_unused),
    .fall_o (bclk_fe)
  );

  ch_e wclk_ch;
  assign wclk_ch = ch_e'(wclk);

  logic                wclk_last_q, wclk_last_d;
  logic [DATA_W-1:0]   sh_q, sh_d;
  logic [DATA_W-1:0]   cur_r_q, cur_r_d;
  logic [2*DATA_W-1:0] hold_q, hold_d;
  logic                hold_valid_q, hold_valid_d;
  logic                sdata_q, sdata_d;
  logic                frame_start_q, frame_start_d;
  logic                underrun_q, underrun_d;
  logic [15:0]         underrun_cnt_q, underrun_cnt_d;
  logic                boundary;
  logic                xfer;

  assign boundary = bclk_fe && (wclk != wclk_last_q);
  assign s_tready = en && !hold_valid_q;
  assign xfer     = s_tvalid && s_tready;

  always_comb begin
    wclk_last_d    = wclk_last_q;
    sh_d           = sh_q;
    cur_r_d        = cur_r_q;
    hold_d         = hold_q;
    hold_valid_d   = hold_valid_q;
    sdata_d        = sdata_q;
    frame_start_d  = 1'b0;
    underrun_d     = 1'b0;
    underrun_cnt_d = underrun_cnt_q;

    if (bclk_fe) begin
      wclk_last_d = wclk;
    end

    if (xfer) begin
      hold_d       = s_tdata;
      hold_valid_d = 1'b1;
    end

    // Disabled: keep the line silent but let hold survive so the pair goes out once re-enabled.
    if (!en) begin
      sh_d    = '0;
      cur_r_d = '0;
      sdata_d = 1'b0;
    end else if (bclk_fe) begin
      sdata_d = sh_q[DATA_W-1];
      if (!boundary) begin
        sh_d = sh_q << 1;
      end else if (wclk_ch == CH_RIGHT) begin
        sh_d = cur_r_q;
      end else begin
        frame_start_d = 1'b1;
        if (hold_valid_q) begin
          sh_d         = hold_q[2*DATA_W-1:DATA_W];
          cur_r_d      = hold_q[DATA_W-1:0];
          hold_valid_d = 1'b0;
        end else begin
          sh_d       = '0;
          cur_r_d    = '0;
          underrun_d = 1'b1;
          if (underrun_cnt_q != 16'hFFFF) begin
            underrun_cnt_d = underrun_cnt_q + 16'd1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wclk_last_q    <= 1'b0;
      sh_q           <= '0;
      cur_r_q        <= '0;
      hold_q         <= '0;
      hold_valid_q   <= 1'b0;
      sdata_q        <= 1'b0;
      frame_start_q  <= 1'b0;
      underrun_q     <= 1'b0;
      underrun_cnt_q <= '0;
    end else begin
      wclk_last_q    <= wclk_last_d;
      sh_q           <= sh_d;
      cur_r_q        <= cur_r_d;
      hold_q         <= hold_d;
      hold_valid_q   <= hold_valid_d;
      sdata_q        <= sdata_d;
      frame_start_q  <= frame_start_d;
      underrun_q     <= underrun_d;
      underrun_cnt_q <= underrun_cnt_d;
    end
  end

  assign sdata        = sdata_q;
  assign frame_start  = frame_start_q;
  assign underrun     = underrun_q;
  assign underrun_cnt = underrun_cnt_q;

endmodule
